mul16_iter_sched: RTL and testbench
===================================

Name: mul16_iter_sched

Overview:
- Time-shared 16x16 unsigned multiplier service for up to NREQ requesters.
- One 8x8 combinational core is reused over four cycles per operation, with partial products accumulated into a 32-bit register.
- A round-robin arbiter picks the next requester.
- Sits between client blocks needing occasional products and the multiplier datapath, replacing one full 16x16 array per client.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID returned with the result.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NREQ, per-requester operation request.
- req_ready, output, NREQ, one-hot grant/accept; at most one bit high.
- req_a, input, NREQ*16, operand A; requester i uses bits [16i+15:16i].
- req_b, input, NREQ*16, operand B; same packing as req_a.
- rsp_valid, output, 1, result available.
- rsp_ready, input, 1, consumer accepts result.
- rsp_id, output, IDW, index of the requester whose product is presented.
- rsp_p, output, 32, unsigned product A*B.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; rsp_valid 0, rsp_p 0, rsp_id 0; req_ready all 0; busy 0; RR pointer 0; accumulator 0; step counter 0.
- Reset is asynchronous. rst_n low mid-operation discards the in-flight product with no response, clears everything as above, and takes effect immediately, not at the next edge.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - req_ready is combinational: a one-hot bit for the first requester with req_valid=1, searching from the RR pointer upward with wrap.
  - Accept happens on the edge where req_ready[i]&req_valid[i]=1.
  - On accept: capture A, B and ID into internal registers, clear accumulator, set step=0, go to MUL, set RR pointer to (i+1) mod NREQ.
  - No valid requests: stay in IDLE, all req_ready 0, pointer unchanged.
- MUL: four cycles, one partial product per edge, using the 8x8 core output pp (16 bits).
  - step0: A[7:0]*B[7:0], added at shift 0.
  - step1: A[15:8]*B[7:0], added at shift 8.
  - step2: A[7:0]*B[15:8], added at shift 8.
  - step3: A[15:8]*B[15:8], added at shift 16.
  - Accumulator is 32 bits; the true product never exceeds 32 bits, so no overflow handling is required.
  - After the step3 edge: go to DONE, register rsp_p = accumulator total and rsp_id = captured ID, set rsp_valid=1.
  - req_ready is all 0 throughout MUL.
- DONE:
  - rsp_valid=1 with rsp_p and rsp_id stable until the edge where rsp_ready=1.
  - That edge returns to IDLE and clears rsp_valid. No new acceptance is allowed in the same cycle.
  - req_ready is all 0 throughout DONE.
- Latency: accept in cycle 0 gives rsp_valid high in cycle 5 with rsp_ready held high. Throughput is 1 op per 6 cycles.
- Operands are captured at accept, so a requester may change req_a/req_b or drop req_valid after acceptance without effect.
- Requesters must hold req_valid and operands stable until granted. Dropping req_valid before grant simply withdraws the request; no error.
- Simultaneous requests: strict round-robin from the pointer. Every continuously-requesting client is granted within NREQ operations.
- Zero operands still take the full four MUL cycles; there is no early termination.

Decomposition:
- Shared package mul_sched_pkg:
  - state enum {IDLE, MUL, DONE}
  - STEP_N=4
  - per-step shift constants {0, 8, 8, 16}
  - operand width constant 16
- Sub-module: mul8_core, an 8x8 unsigned combinational multiplier (16-bit output), instantiated once.
  - Selection of operand halves, the shifter, the accumulator and the RR arbiter stay in the top.

Test Plan:
- Single request on req 0: A=12345, B=54321 -> req_ready[0] for one cycle; rsp_valid in cycle 5; rsp_p=670592745; rsp_id=0.
- Corner operands: A=0xFFFF, B=0xFFFF -> rsp_p=0xFFFE0001. A=32767, B=2 -> 65534. A=0, B=0xFFFF -> 0.
- All 4 requesters valid continuously after reset, consuming each response -> grant order 0,1,2,3,0; each rsp_id matches and products are correct.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE -> rsp_valid, rsp_p and rsp_id stay stable; no req_ready asserted; release gives IDLE next cycle.
- Reset mid-operation: drop rst_n during step2 -> all outputs 0 immediately, no response. Then req 2 and req 0 valid together -> req 0 granted first (pointer reset) with correct product.
- Withdrawal and operand change: req 1 drops valid before grant -> no grant to req 1. A granted requester changing operands in the cycle after accept -> result uses the captured values.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the time-shared 16x16 multiplier scheduler.
// Holds the FSM encoding, the step count and the per-step partial-product alignment.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STEP_N = 4;
  localparam int OPW    = 16;

  localparam logic [4:0] SHIFT_S0 = 5'd0;
  localparam logic [4:0] SHIFT_S1 = 5'd8;
  localparam logic [4:0] SHIFT_S2 = 5'd8;
  localparam logic [4:0] SHIFT_S3 = 5'd16;

  function automatic logic [4:0] step_shift(input logic [1:0] step);
    logic [4:0] sh;
    case (step)
      2'd0:    sh = SHIFT_S0;
      2'd1:    sh = SHIFT_S1;
      2'd2:    sh = SHIFT_S2;
      default: sh = SHIFT_S3;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul8_core.sv
// 8x8 unsigned combinational multiplier, zero latency, no flow control.
// Shared by all requesters through the scheduler's operand-half mux.
module mul8_core (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = {8'b0, a} * {8'b0, b};

endmodule

// File: rtl/mul16_iter_sched.sv
// Round-robin 16x16 multiplier service on one 8x8 core: accept -> rsp_valid 5 cycles later.
// One op in flight; result held in DONE until rsp_ready, no new grants meanwhile.
module mul16_iter_sched
  import mul_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OPW-1:0]   req_a,
  input  logic [NREQ*OPW-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_p,
  output logic                  busy
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   next_ptr;
  logic             grant_found;
  logic [OPW-1:0]   sel_a;
  logic [OPW-1:0]   sel_b;
  logic [OPW-1:0]   op_a;
  logic [OPW-1:0]   op_b;
  logic [IDW-1:0]   op_id;
  logic [31:0]      acc;
  logic [31:0]      addend;
  logic [1:0]       step;
  logic [7:0]       core_a;
  logic [7:0]       core_b;
  logic [15:0]      pp;

  // Two passes: requesters at or above the pointer win first, then wrap to the bottom.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
  end

  assign next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
  assign req_ready = ((state == IDLE) && grant_found) ? (NREQ'(1) << grant_id) : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id) begin
        sel_a = req_a[i*OPW +: OPW];
        sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    core_a = op_a[7:0];
    core_b = op_b[7:0];
    case (step)
      2'd1: begin core_a = op_a[15:8]; core_b = op_b[7:0];  end
      2'd2: begin core_a = op_a[7:0];  core_b = op_b[15:8]; end
      2'd3: begin core_a = op_a[15:8]; core_b = op_b[15:8]; end
      default: ;
    endcase
  end

  mul8_core u_core (
    .a (core_a),
    .b (core_b),
    .p (pp)
  );

  assign addend = {16'b0, pp} << step_shift(step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      acc       <= '0;
      step      <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= grant_id;
            acc    <= '0;
            step   <= '0;
            rr_ptr <= next_ptr;
            state  <= MUL;
          end
        end
        MUL: begin
          acc  <= acc + addend;
          step <= step + 2'd1;
          if (step == 2'(STEP_N - 1)) begin
            rsp_p     <= acc + addend;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_iter_sched.sv
// Directed bench for mul16_iter_sched: reset, latency, corners, round robin,
// backpressure, mid-op reset, withdrawal and operand capture.
module tb_mul16_iter_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*16-1:0]  req_a;
  logic [NREQ*16-1:0]  req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_p;
  logic                busy;

  int n_checks;
  int n_fail;

  mul16_iter_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Drives one request to completion with rsp_ready high; reports what came back.
  task automatic run_op(input int r, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output logic [IDW-1:0] id, output logic ok);
    ok = 1'b0;
    p  = '0;
    id = '0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_a[r*16 +: 16] = a;
    req_b[r*16 +: 16] = b;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready[r]) break;
      tick();
    end
    if (!req_ready[r]) begin
      req_valid = '0;
      return;
    end
    tick();
    req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) break;
      tick();
    end
    if (!rsp_valid) return;
    p  = rsp_p;
    id = rsp_id;
    ok = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    #3;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    n_checks++;
    if (rsp_p !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_p: got %0d expected 0", rsp_p); end
    n_checks++;
    if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_a[15:0] = 16'd12345;
    req_b[15:0] = 16'd54321;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_mul_state: req_ready %b busy %0b expected 0000 1", req_ready, busy);
    end
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp cycle %0d: got %0b expected 0", c, rsp_valid); end
      tick();
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: rsp_valid %0b expected 1 in cycle 5", rsp_valid); end
    n_checks++;
    if (rsp_p !== 32'd670592745) begin n_fail++; $display("FAIL single_product: got %0d expected 670592745", rsp_p); end
    n_checks++;
    if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", rsp_id); end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_return_idle: rsp_valid %0b busy %0b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_corners();
    logic [15:0]    ta [3];
    logic [15:0]    tb [3];
    logic [31:0]    tp [3];
    logic [31:0]    p;
    logic [IDW-1:0] id;
    logic           ok;
    ta[0] = 16'hFFFF; tb[0] = 16'hFFFF; tp[0] = 32'hFFFE0001;
    ta[1] = 16'd32767; tb[1] = 16'd2;   tp[1] = 32'd65534;
    ta[2] = 16'd0;    tb[2] = 16'hFFFF; tp[2] = 32'd0;
    for (int k = 0; k < 3; k++) begin
      run_op(0, ta[k], tb[k], p, id, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL corner%0d_timeout: completed %0b expected 1", k, ok); end
      n_checks++;
      if (p !== tp[k]) begin n_fail++; $display("FAIL corner%0d_product: got %h expected %h", k, p, tp[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int          ord [5];
    logic [31:0] exp_p [4];
    apply_reset();
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
    req_a[15:0]  = 16'd100;   req_b[15:0]  = 16'd200;   exp_p[0] = 32'd20000;
    req_a[31:16] = 16'h1234;  req_b[31:16] = 16'h0010;  exp_p[1] = 32'h00012340;
    req_a[47:32] = 16'hFF00;  req_b[47:32] = 16'h0100;  exp_p[2] = 32'h00FF0000;
    req_a[63:48] = 16'd300;   req_b[63:48] = 16'd300;   exp_p[3] = 32'd90000;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 20; c++) begin
        if (req_ready != 4'b0000) break;
        tick();
      end
      n_checks++;
      if (req_ready !== (4'b0001 << ord[k])) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, 4'b0001 << ord[k]);
      end
      tick();
      for (int c = 0; c < 20; c++) begin
        if (rsp_valid) break;
        tick();
      end
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(ord[k])) begin
        n_fail++; $display("FAIL rr_id%0d: valid %0b id %0d expected 1 %0d", k, rsp_valid, rsp_id, ord[k]);
      end
      n_checks++;
      if (rsp_p !== exp_p[ord[k]]) begin
        n_fail++; $display("FAIL rr_product%0d: got %h expected %h", k, rsp_p, exp_p[ord[k]]);
      end
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    req_a[63:48] = 16'h0102;
    req_b[63:48] = 16'h0304;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready[3]) break;
      tick();
    end
    n_checks++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant: got %b expected 1000", req_ready); end
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) break;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== 32'd199176 || rsp_id !== 2'd3) begin
        n_fail++; $display("FAIL bp_hold%0d: valid %0b p %0d id %0d expected 1 199176 3", c, rsp_valid, rsp_p, rsp_id);
      end
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant%0d: got %b expected 0000", c, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_release: busy %0b valid %0b req_ready %b expected 0 0 0010", busy, rsp_valid, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    req_a[31:16] = 16'h1234;
    req_b[31:16] = 16'h5678;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state: busy %0b valid %0b expected 0 0", busy, rsp_valid);
    end
    n_checks++;
    if (rsp_p !== 32'd0 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset_rsp: p %0d id %0d expected 0 0", rsp_p, rsp_id);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_response: got %0b expected 0", seen); end
    req_a[15:0]  = 16'd1111; req_b[15:0]  = 16'd3;
    req_a[47:32] = 16'd50;   req_b[47:32] = 16'd60;
    req_valid = 4'b0101;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_reset: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) break;
      tick();
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 32'd3333 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL mid_first_op: valid %0b p %0d id %0d expected 1 3333 0", rsp_valid, rsp_p, rsp_id);
    end
    tick();
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_second_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) break;
      tick();
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 32'd3000 || rsp_id !== 2'd2) begin
      n_fail++; $display("FAIL mid_second_op: valid %0b p %0d id %0d expected 1 3000 2", rsp_valid, rsp_p, rsp_id);
    end
    tick();
  endtask

  task automatic test_withdraw();
    logic seen;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_a[15:0] = 16'h00FF;
    req_b[15:0] = 16'h0101;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wd_grant: got %b expected 0001", req_ready); end
    tick();
    req_a[15:0] = 16'hFFFF;
    req_b[15:0] = 16'hFFFF;
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_mul_ready: got %b expected 0000", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) break;
      tick();
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 32'd65535 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL wd_captured: valid %0b p %0d id %0d expected 1 65535 0", rsp_valid, rsp_p, rsp_id);
    end
    tick();
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (req_ready != 4'b0000 || busy) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL wd_no_grant: activity %0b expected 0", seen); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
